// File: rtl/maze_mem_arb.sv
// Two-port arbiter sharing the single-port maze memory, with locked bursts and tagged read return.
// Optional feature macro: MAZE_ARB_RR_EN (round-robin contention plus MAX_BURST cap on locked owners).
module maze_mem_arb #(
  parameter int MAZE_WIDTH = 6,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  wdata0,
  input  logic                  wdata1,
  input  logic [MAZE_WIDTH-1:0] row0,
  input  logic [MAZE_WIDTH-1:0] col0,
  input  logic [MAZE_WIDTH-1:0] row1,
  input  logic [MAZE_WIDTH-1:0] col1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  rdata,
  output logic [MAZE_WIDTH-1:0] mem_row,
  output logic [MAZE_WIDTH-1:0] mem_col,
  output logic                  mem_oe,
  output logic                  mem_we,
  output logic                  mem_wdata,
  input  logic                  mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

`ifdef MAZE_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_t                state_reg, state_next;
  logic                  last_reg, last_next;   // 1 = port 1 was served last
  logic [3:0]            count_reg, count_next;
  logic                  win0, win1;
  logic                  below_max;
  logic [MAZE_WIDTH-1:0] mem_row_reg, mem_col_reg;
  logic                  mem_oe_reg, mem_we_reg, mem_wdata_reg;
  logic                  tag_valid_reg, tag_port_reg;
  logic                  rvalid0_reg, rvalid1_reg;

  assign below_max = (count_reg < BURST_MAX);

  // Without round-robin, a locked port 0 never yields and port 0 always breaks a lock on port 1.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    case (state_reg)
      OWN0: begin
        win0 = req0 && (!req1 || !RR || below_max);
        win1 = req1 && !win0;
      end
      OWN1: begin
        win1 = req1 && (!req0 || (RR && below_max));
        win0 = req0 && !win1;
      end
      default: begin
        win0 = req0 && (!req1 || !RR || last_reg);
        win1 = req1 && !win0;
      end
    endcase
    if (rst) begin
      win0 = 1'b0;
      win1 = 1'b0;
    end
  end

  assign gnt0 = win0;
  assign gnt1 = win1;

  always_comb begin
    state_next = IDLE;
    last_next  = last_reg;
    count_next = '0;
    if (win0 || win1) begin
      last_next = win1;
      if (win0 ? lock0 : lock1) begin
        state_next = win0 ? OWN0 : OWN1;
        // A fresh owner starts counting at 1; an unchallenged owner saturates at the cap.
        if (state_reg != state_next)
          count_next = 4'd1;
        else if (count_reg >= BURST_MAX)
          count_next = count_reg;
        else
          count_next = count_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      count_reg     <= '0;
      mem_row_reg   <= '0;
      mem_col_reg   <= '0;
      mem_oe_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_wdata_reg <= 1'b0;
      tag_valid_reg <= 1'b0;
      tag_port_reg  <= 1'b0;
      rvalid0_reg   <= 1'b0;
      rvalid1_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      last_reg   <= last_next;
      count_reg  <= count_next;
      mem_oe_reg <= (win0 && !we0) || (win1 && !we1);
      mem_we_reg <= (win0 && we0) || (win1 && we1);
      if (win0 || win1) begin
        mem_row_reg   <= win1 ? row1 : row0;
        mem_col_reg   <= win1 ? col1 : col0;
        mem_wdata_reg <= win1 ? wdata1 : wdata0;
      end
      tag_valid_reg <= (win0 && !we0) || (win1 && !we1);
      tag_port_reg  <= win1;
      rvalid0_reg   <= tag_valid_reg && !tag_port_reg;
      rvalid1_reg   <= tag_valid_reg && tag_port_reg;
    end
  end

  assign mem_row   = mem_row_reg;
  assign mem_col   = mem_col_reg;
  assign mem_oe    = mem_oe_reg;
  assign mem_we    = mem_we_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rvalid0   = rvalid0_reg;
  assign rvalid1   = rvalid1_reg;
  assign rdata     = (rvalid0_reg || rvalid1_reg) && mem_rdata;

endmodule

// File: tb/tb_maze_mem_arb.sv
// Bench for maze_mem_arb: directed scenarios plus random traffic against a behavioural arbiter/memory model.
module tb_maze_mem_arb;
  localparam int MW = 6;
  localparam int MB = 8;
  localparam int NCELL = 1 << (2 * MW);
`ifdef MAZE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, wdata0 = 0, wdata1 = 0, lock0 = 0, lock1 = 0;
  logic [MW-1:0] row0 = '0, col0 = '0, row1 = '0, col1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, rdata;
  logic [MW-1:0] mem_row, mem_col;
  logic mem_oe, mem_we, mem_wdata;
  logic mem_rdata = 1'b0;

  maze_mem_arb #(.MAZE_WIDTH(MW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .wdata0(wdata0), .wdata1(wdata1),
    .row0(row0), .col0(col0), .row1(row1), .col1(col1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_row(mem_row), .mem_col(mem_col), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory the DUT drives, and the reference contents the model updates in grant order.
  logic mem_arr [0:NCELL-1];
  logic ref_mem [0:NCELL-1];

  always @(posedge clk) begin
    if (mem_oe) mem_rdata <= mem_arr[int'(mem_row) * (1 << MW) + int'(mem_col)];
    if (mem_we) mem_arr[int'(mem_row) * (1 << MW) + int'(mem_col)] <= mem_wdata;
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: owner 0=none, 1=port0, 2=port1; expected strobe for next cycle; read tags for +1/+2 cycles.
  int m_owner = 0, m_cnt = 0, m_last = 1;
  bit armed = 0;
  int s_oe = 0, s_we = 0, s_row = 0, s_col = 0, s_wd = 0;
  int t1_v = 0, t1_p = 0, t1_d = 0;
  int t2_v = 0, t2_p = 0, t2_d = 0;

  always @(negedge clk) begin
    int w, idx, pw, prow, pcol, pwd, plk;
    if (armed) begin
      chk("mem_oe", mem_oe, s_oe);
      chk("mem_we", mem_we, s_we);
      chk("mem_row", mem_row, s_row);
      chk("mem_col", mem_col, s_col);
      chk("mem_wdata", mem_wdata, s_wd);
      chk("rvalid0", rvalid0, (t2_v != 0 && t2_p == 0) ? 1 : 0);
      chk("rvalid1", rvalid1, (t2_v != 0 && t2_p == 1) ? 1 : 0);
      chk("rdata", rdata, (t2_v != 0) ? t2_d : 0);
    end
    if (rst) begin
      chk("gnt0_rst", gnt0, 0);
      chk("gnt1_rst", gnt1, 0);
      m_owner = 0; m_cnt = 0; m_last = 1;
      s_oe = 0; s_we = 0; s_row = 0; s_col = 0; s_wd = 0;
      t1_v = 0; t2_v = 0;
      armed = 1;
    end else if (armed) begin
      if (req0 && req1) begin
        case (m_owner)
          1: w = (!RR || m_cnt < MB) ? 0 : 1;
          2: w = (RR && m_cnt < MB) ? 1 : 0;
          default: w = (RR && m_last == 0) ? 1 : 0;
        endcase
      end else if (req0) w = 0;
      else if (req1) w = 1;
      else w = -1;
      chk("gnt0", gnt0, (w == 0) ? 1 : 0);
      chk("gnt1", gnt1, (w == 1) ? 1 : 0);
      t2_v = t1_v; t2_p = t1_p; t2_d = t1_d;
      if (w >= 0) begin
        pw   = (w == 0) ? int'(we0) : int'(we1);
        prow = (w == 0) ? int'(row0) : int'(row1);
        pcol = (w == 0) ? int'(col0) : int'(col1);
        pwd  = (w == 0) ? int'(wdata0) : int'(wdata1);
        plk  = (w == 0) ? int'(lock0) : int'(lock1);
        idx  = prow * (1 << MW) + pcol;
        s_oe = (pw == 0) ? 1 : 0; s_we = pw; s_row = prow; s_col = pcol; s_wd = pwd;
        t1_v = (pw == 0) ? 1 : 0; t1_p = w; t1_d = int'(ref_mem[idx]);
        if (pw != 0) ref_mem[idx] = pwd[0];
        if (plk != 0) begin
          m_cnt = (m_owner == w + 1) ? ((m_cnt < MB) ? m_cnt + 1 : m_cnt) : 1;
          m_owner = w + 1;
        end else begin
          m_owner = 0; m_cnt = 0;
        end
        m_last = w;
      end else begin
        s_oe = 0; s_we = 0; t1_v = 0;
        m_owner = 0; m_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    step();
    rst = 0;
  endtask

  initial begin
    logic g0, g1;
    for (int i = 0; i < NCELL; i++) begin
      mem_arr[i] = 1'($urandom_range(0, 1));
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[5 * 64 + 9] = 1'b1;
    ref_mem[5 * 64 + 9] = 1'b1;

    // Reset state
    step(); step();
    at_neg();
    chk("reset_gnt0", gnt0, 0);
    chk("reset_mem_oe", mem_oe, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_row", mem_row, 0);
    chk("reset_rvalid0", rvalid0, 0);
    chk("reset_rdata", rdata, 0);

    // Single read of cell (5,9) which holds 1
    do_reset();
    req0 = 1; we0 = 0; row0 = 6'd5; col0 = 6'd9;
    at_neg(); chk("read_gnt0", gnt0, 1);
    step(); req0 = 0;
    at_neg(); chk("read_mem_oe", mem_oe, 1); chk("read_mem_row", mem_row, 5); chk("read_mem_col", mem_col, 9);
    step();
    at_neg(); chk("read_rvalid0", rvalid0, 1); chk("read_rdata", rdata, 1);

    // Unlocked contention
    do_reset();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; row0 = 1; col0 = 2; row1 = 3; col1 = 4;
    for (int i = 0; i < 6; i++) begin
      at_neg(); chk("contend_gnt0", gnt0, (!RR || (i % 2 == 0)) ? 1 : 0);
      step();
    end

    // Locked burst from port 0 with port 1 waiting
    do_reset();
    req0 = 1; req1 = 1; lock0 = 1;
    for (int i = 0; i < 12; i++) begin
      at_neg(); chk("burst_gnt1", gnt1, (RR && i == MB) ? 1 : 0);
      step();
    end

    // Read-then-mark on port 0 while port 1 waits
    do_reset();
    req1 = 1; we1 = 0; row1 = 1; col1 = 1;
    req0 = 1; we0 = 0; lock0 = 1; row0 = 7; col0 = 3;
    at_neg(); chk("mark_gnt0_rd", gnt0, 1);
    step(); we0 = 1; wdata0 = 1; lock0 = 0;
    at_neg(); chk("mark_gnt0_wr", gnt0, 1); chk("mark_gnt1_hold", gnt1, 0);
    chk("mark_mem_oe", mem_oe, 1); chk("mark_mem_row", mem_row, 7);
    step(); req0 = 0;
    at_neg(); chk("mark_gnt1", gnt1, 1); chk("mark_mem_we", mem_we, 1); chk("mark_mem_oe0", mem_oe, 0);
    chk("mark_mem_col", mem_col, 3); chk("mark_mem_wdata", mem_wdata, 1);
    step(); req1 = 0;
    at_neg(); chk("mark_p1_oe", mem_oe, 1); chk("mark_p1_row", mem_row, 1);

    // Reset while a read is in flight
    do_reset();
    req0 = 1; we0 = 0; row0 = 2; col0 = 2;
    at_neg(); chk("rstmid_gnt0", gnt0, 1);
    step(); rst = 1; req0 = 0;
    at_neg(); chk("rstmid_strobe", mem_oe, 1);
    step(); rst = 0;
    at_neg(); chk("rstmid_oe0", mem_oe, 0); chk("rstmid_row0", mem_row, 0);
    chk("rstmid_rvalid0", rvalid0, 0); chk("rstmid_rdata", rdata, 0);
    step();
    at_neg(); chk("rstmid_rvalid0_late", rvalid0, 0);

    // Write-only access from port 1
    do_reset();
    req1 = 1; we1 = 1; wdata1 = 1; row1 = 6'd63; col1 = 6'd0;
    at_neg(); chk("wr_gnt1", gnt1, 1);
    step(); req1 = 0;
    at_neg(); chk("wr_mem_we", mem_we, 1); chk("wr_mem_oe", mem_oe, 0);
    chk("wr_mem_row", mem_row, 63); chk("wr_mem_col", mem_col, 0);
    step();
    at_neg(); chk("wr_rvalid1", rvalid1, 0);

    // Random traffic; requests held until granted, occasionally withdrawn or reset
    do_reset();
    g0 = 0; g1 = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!req0 || g0) begin
        req0 = ($urandom_range(0, 99) < 65);
        we0 = ($urandom_range(0, 2) == 0); wdata0 = 1'($urandom_range(0, 1));
        lock0 = ($urandom_range(0, 1) == 1);
        row0 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 2));
        col0 = 6'($urandom_range(0, 2));
      end else if ($urandom_range(0, 31) == 0) req0 = 0;
      if (!req1 || g1) begin
        req1 = ($urandom_range(0, 99) < 65);
        we1 = ($urandom_range(0, 2) == 0); wdata1 = 1'($urandom_range(0, 1));
        lock1 = ($urandom_range(0, 1) == 1);
        row1 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 2));
        col1 = 6'($urandom_range(0, 2));
      end else if ($urandom_range(0, 31) == 0) req1 = 0;
      at_neg(); g0 = gnt0; g1 = gnt1;
      step();
    end
    rst = 0; req0 = 0; req1 = 0;
    repeat (3) step();
    at_neg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
